// File: rtl/simple_tmr_pkg.sv
// Shared constants and helpers for the simple-bus timer/compare peripheral.
// Word indexes, control/status bit positions, access-size codes and lane merge.
package simple_tmr_pkg;

  localparam logic [2:0] CTRL_IDX = 3'd0;
  localparam logic [2:0] PSC_IDX  = 3'd1;
  localparam logic [2:0] CMP_IDX  = 3'd2;
  localparam logic [2:0] CNT_IDX  = 3'd3;
  localparam logic [2:0] STAT_IDX = 3'd4;

  localparam int EN_B         = 0;
  localparam int AR_B         = 1;
  localparam int IE_B         = 2;
  localparam int STAT_MATCH_B = 0;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  // Replace only the byte lanes selected by be; the rest keep old_val.
  function automatic logic [31:0] merge_lanes(input logic [31:0] old_val,
                                              input logic [31:0] wr_val,
                                              input logic [3:0]  be);
    logic [31:0] merged;
    merged = old_val;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) merged[8*i +: 8] = wr_val[8*i +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/simple_tmr_slv_if.sv
// Simple-bus slave port bundle: address, write strobe/data, size and read data.
interface simple_tmr_slv_if;
  logic [31:0] addr;
  logic        we;
  logic [31:0] wd;
  logic [31:0] rd;
  logic [1:0]  size;

  modport master (output addr, we, wd, size, input rd);
  modport slave  (input addr, we, wd, size, output rd);
endinterface

// File: rtl/simple_be_gen.sv
// Byte-enable generator for simple-bus slaves: low address bits + size -> lanes.
module simple_be_gen
  import simple_tmr_pkg::*;
(
  input  logic [1:0] addr_lo,
  input  logic [1:0] size,
  output logic [3:0] be
);

  always_comb begin
    be = 4'b0000;
    case (size)
      SZ_BYTE: be[addr_lo] = 1'b1;
      SZ_HALF: be = addr_lo[1] ? 4'b1100 : 4'b0011;
      default: be = 4'b1111;
    endcase
  end

endmodule

// File: rtl/simple_tmr_slv.sv
// Register-mapped prescaled up-counter with compare match, one-shot or
// auto-reload operation and a level interrupt, on a simple-bus slave port.
module simple_tmr_slv
  import simple_tmr_pkg::*;
#(
  parameter int CNT_W = 32,
  parameter int PSC_W = 16
) (
  input  logic             clk,
  input  logic             rstn,
  simple_tmr_slv_if.slave  bus,
  output logic             irq
);

  logic [2:0]       ctrl_reg;
  logic [PSC_W-1:0] psc_reg;
  logic [PSC_W-1:0] psc_cnt_reg;
  logic [CNT_W-1:0] cmp_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic             match_reg;

  logic [3:0] be;
  logic [2:0] idx;
  logic       wr_ctrl, wr_psc, wr_cmp, wr_cnt, w1c_match;
  logic       tick, at_cmp, match_ev;
  logic       unused_addr_bits;

  assign idx              = bus.addr[4:2];
  assign unused_addr_bits = ^bus.addr[31:5];

  simple_be_gen u_be_gen (
    .addr_lo (bus.addr[1:0]),
    .size    (bus.size),
    .be      (be)
  );

  // CTRL only counts as written when its low lane is enabled, so a stray
  // upper-byte write cannot mask the one-shot auto-disable.
  assign wr_ctrl   = bus.we && (idx == CTRL_IDX) && be[0];
  assign wr_psc    = bus.we && (idx == PSC_IDX);
  assign wr_cmp    = bus.we && (idx == CMP_IDX);
  assign wr_cnt    = bus.we && (idx == CNT_IDX);
  assign w1c_match = bus.we && (idx == STAT_IDX) && be[0] && bus.wd[STAT_MATCH_B];

  assign tick     = ctrl_reg[EN_B] && (psc_cnt_reg == psc_reg);
  assign at_cmp   = (cnt_reg == cmp_reg);
  assign match_ev = tick && at_cmp && !wr_cnt;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ctrl_reg    <= '0;
      psc_reg     <= '0;
      psc_cnt_reg <= '0;
      cmp_reg     <= '1;
      cnt_reg     <= '0;
      match_reg   <= 1'b0;
    end else begin
      if (wr_ctrl) begin
        ctrl_reg <= 3'(merge_lanes(32'(ctrl_reg), bus.wd, be));
      end else if (match_ev && !ctrl_reg[AR_B]) begin
        ctrl_reg[EN_B] <= 1'b0;
      end

      if (wr_psc) begin
        psc_reg <= PSC_W'(merge_lanes(32'(psc_reg), bus.wd, be));
      end

      if (wr_psc || !ctrl_reg[EN_B] || tick) begin
        psc_cnt_reg <= '0;
      end else begin
        psc_cnt_reg <= psc_cnt_reg + PSC_W'(1);
      end

      // A compare at a write edge still sees the old CMP value.
      if (wr_cmp) begin
        cmp_reg <= CNT_W'(merge_lanes(32'(cmp_reg), bus.wd, be));
      end

      if (wr_cnt) begin
        cnt_reg <= CNT_W'(merge_lanes(32'(cnt_reg), bus.wd, be));
      end else if (tick) begin
        if (at_cmp) begin
          if (ctrl_reg[AR_B]) cnt_reg <= '0;
        end else begin
          cnt_reg <= cnt_reg + CNT_W'(1);
        end
      end

      // A new match beats a simultaneous write-1-to-clear.
      if (match_ev) begin
        match_reg <= 1'b1;
      end else if (w1c_match) begin
        match_reg <= 1'b0;
      end
    end
  end

  always_comb begin
    bus.rd = 32'h0;
    case (idx)
      CTRL_IDX: bus.rd = 32'(ctrl_reg);
      PSC_IDX:  bus.rd = 32'(psc_reg);
      CMP_IDX:  bus.rd = 32'(cmp_reg);
      CNT_IDX:  bus.rd = 32'(cnt_reg);
      STAT_IDX: bus.rd = 32'(match_reg);
      default:  bus.rd = 32'h0;
    endcase
  end

  assign irq = match_reg & ctrl_reg[IE_B];

endmodule

// File: tb/tb_simple_tmr_slv.sv
// Directed bench for simple_tmr_slv: a 32-bit and an 8-bit instance, expected
// values queued as each step is driven and popped when the outputs are sampled.
module tb_simple_tmr_slv;
  import simple_tmr_pkg::*;

  logic clk = 1'b0;
  logic rstn = 1'b1;
  logic irq0, irq8;

  simple_tmr_slv_if bus0 ();
  simple_tmr_slv_if bus8 ();

  simple_tmr_slv #(.CNT_W(32), .PSC_W(16)) dut (
    .clk (clk), .rstn (rstn), .bus (bus0.slave), .irq (irq0)
  );

  simple_tmr_slv #(.CNT_W(8), .PSC_W(16)) dut8 (
    .clk (clk), .rstn (rstn), .bus (bus8.slave), .irq (irq8)
  );

  always #50 clk = ~clk;

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } sb_t;

  sb_t sb_q[$];
  int  checks = 0;
  int  failures = 0;

  task automatic drive(input bit s, input logic [31:0] a, input logic [31:0] d,
                       input logic [1:0] sz, input logic w);
    if (s) begin
      bus8.addr = a; bus8.wd = d; bus8.size = sz; bus8.we = w;
    end else begin
      bus0.addr = a; bus0.wd = d; bus0.size = sz; bus0.we = w;
    end
  endtask

  // One bus write: occupies exactly one rising edge, returns on the next falling edge.
  task automatic wr(input bit s, input logic [31:0] a, input logic [31:0] d,
                    input logic [1:0] sz);
    drive(s, a, d, sz, 1'b1);
    @(negedge clk);
    drive(s, a, d, sz, 1'b0);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic compare(input logic [31:0] obs);
    sb_t e;
    e = sb_q.pop_front();
    checks++;
    assert (obs === e.exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.exp);
    end
  endtask

  task automatic rd_chk(input bit s, input logic [31:0] a, input logic [31:0] exp,
                        input string tag);
    sb_q.push_back('{tag, exp});
    drive(s, a, 32'h0, SZ_WORD, 1'b0);
    #1;
    compare(s ? bus8.rd : bus0.rd);
    $display("check %-14s addr=%h rd=%h", tag, a, s ? bus8.rd : bus0.rd);
  endtask

  task automatic irq_chk(input bit s, input logic exp, input string tag);
    sb_q.push_back('{tag, 32'(exp)});
    #1;
    compare(32'(s ? irq8 : irq0));
    $display("check %-14s irq=%0b", tag, s ? irq8 : irq0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    drive(0, 32'h0, 32'h0, SZ_WORD, 1'b0);
    drive(1, 32'h0, 32'h0, SZ_WORD, 1'b0);

    // Reset asserted in the middle of a clock phase.
    @(negedge clk);
    #20 rstn = 1'b0;
    idle(2);
    rstn = 1'b1;

    rd_chk(0, 32'h00, 32'h0000_0000, "rst_ctrl");
    rd_chk(0, 32'h04, 32'h0000_0000, "rst_psc");
    rd_chk(0, 32'h08, 32'hFFFF_FFFF, "rst_cmp");
    rd_chk(0, 32'h0C, 32'h0000_0000, "rst_cnt");
    rd_chk(0, 32'h10, 32'h0000_0000, "rst_stat");
    rd_chk(0, 32'h14, 32'h0000_0000, "rst_idx5");
    rd_chk(0, 32'h18, 32'h0000_0000, "rst_idx6");
    rd_chk(0, 32'h1C, 32'h0000_0000, "rst_idx7");
    irq_chk(0, 1'b0, "rst_irq");
    rd_chk(1, 32'h08, 32'h0000_00FF, "rst_cmp8");

    // Unused CTRL bits and unmapped words.
    wr(0, 32'h00, 32'hFFFF_FFF8, SZ_WORD);
    rd_chk(0, 32'h00, 32'h0000_0000, "ctrl_rsvd");
    wr(0, 32'h14, 32'hFFFF_FFFF, SZ_WORD);
    rd_chk(0, 32'h14, 32'h0000_0000, "idx5_wr");

    // Byte / halfword lane merge.
    wr(0, 32'h08, 32'h1122_3344, SZ_WORD);
    rd_chk(0, 32'h08, 32'h1122_3344, "cmp_word");
    wr(0, 32'h09, 32'h0000_AA00, SZ_BYTE);
    rd_chk(0, 32'h08, 32'h1122_AA44, "cmp_byte");
    wr(0, 32'h0A, 32'hBBCC_0000, SZ_HALF);
    rd_chk(0, 32'h08, 32'hBBCC_AA44, "cmp_half");
    wr(0, 32'h0B, 32'h5566_0000, SZ_HALF);
    rd_chk(0, 32'h08, 32'h5566_AA44, "cmp_half_a0");

    // Auto-reload, PSC=2: tick every 3 cycles, match 12 edges after enable.
    wr(0, 32'h04, 32'h0000_0002, SZ_WORD);
    wr(0, 32'h08, 32'h0000_0003, SZ_WORD);
    wr(0, 32'h00, 32'h0000_0007, SZ_WORD);
    idle(2);
    rd_chk(0, 32'h0C, 32'd0, "ar_cnt_e2");
    idle(1);
    rd_chk(0, 32'h0C, 32'd1, "ar_cnt_e3");
    idle(3);
    rd_chk(0, 32'h0C, 32'd2, "ar_cnt_e6");
    idle(3);
    rd_chk(0, 32'h0C, 32'd3, "ar_cnt_e9");
    idle(2);
    rd_chk(0, 32'h10, 32'd0, "ar_stat_e11");
    irq_chk(0, 1'b0, "ar_irq_e11");
    idle(1);
    rd_chk(0, 32'h0C, 32'd0, "ar_cnt_e12");
    rd_chk(0, 32'h10, 32'd1, "ar_stat_e12");
    irq_chk(0, 1'b1, "ar_irq_e12");

    // Stop and clear.
    wr(0, 32'h00, 32'h0000_0000, SZ_WORD);
    wr(0, 32'h10, 32'h0000_0001, SZ_WORD);
    rd_chk(0, 32'h10, 32'd0, "w1c_clear");
    irq_chk(0, 1'b0, "w1c_irq");

    // One-shot, PSC=0, CMP=5.
    wr(0, 32'h04, 32'h0000_0000, SZ_WORD);
    wr(0, 32'h08, 32'h0000_0005, SZ_WORD);
    wr(0, 32'h0C, 32'h0000_0000, SZ_WORD);
    wr(0, 32'h00, 32'h0000_0001, SZ_WORD);
    idle(5);
    rd_chk(0, 32'h0C, 32'd5, "os_cnt_e5");
    rd_chk(0, 32'h00, 32'd1, "os_ctrl_e5");
    rd_chk(0, 32'h10, 32'd0, "os_stat_e5");
    idle(1);
    rd_chk(0, 32'h0C, 32'd5, "os_cnt_e6");
    rd_chk(0, 32'h00, 32'd0, "os_ctrl_e6");
    rd_chk(0, 32'h10, 32'd1, "os_stat_e6");
    irq_chk(0, 1'b0, "os_irq_e6");
    idle(2);
    rd_chk(0, 32'h0C, 32'd5, "os_cnt_hold");

    // W1C colliding with a match every cycle.
    wr(0, 32'h10, 32'h0000_0001, SZ_WORD);
    rd_chk(0, 32'h10, 32'd0, "col_pre_clr");
    wr(0, 32'h08, 32'h0000_0000, SZ_WORD);
    wr(0, 32'h0C, 32'h0000_0000, SZ_WORD);
    wr(0, 32'h00, 32'h0000_0007, SZ_WORD);
    idle(1);
    rd_chk(0, 32'h10, 32'd1, "col_match");
    irq_chk(0, 1'b1, "col_irq");
    wr(0, 32'h10, 32'h0000_0001, SZ_WORD);
    rd_chk(0, 32'h10, 32'd1, "col_set_wins");
    wr(0, 32'h00, 32'h0000_0004, SZ_WORD);
    rd_chk(0, 32'h00, 32'd4, "col_ctrl");
    wr(0, 32'h10, 32'h0000_0001, SZ_WORD);
    rd_chk(0, 32'h10, 32'd0, "col_clr");
    irq_chk(0, 1'b0, "col_irq_off");

    // 8-bit counter: width truncation, write priority and wrap.
    wr(1, 32'h04, 32'h0000_0000, SZ_WORD);
    wr(1, 32'h08, 32'hABCD_EF10, SZ_WORD);
    rd_chk(1, 32'h08, 32'h0000_0010, "w8_cmp_trunc");
    wr(1, 32'h00, 32'h0000_0001, SZ_WORD);
    wr(1, 32'h0C, 32'h0000_00FE, SZ_WORD);
    rd_chk(1, 32'h0C, 32'h0000_00FE, "w8_cnt_wr");
    idle(1);
    rd_chk(1, 32'h0C, 32'h0000_00FF, "w8_cnt_ff");
    idle(1);
    rd_chk(1, 32'h0C, 32'h0000_0000, "w8_wrap");
    rd_chk(1, 32'h10, 32'd0, "w8_wrap_stat");
    wr(1, 32'h0C, 32'h0000_0040, SZ_WORD);
    rd_chk(1, 32'h0C, 32'h0000_0040, "w8_wr_prio");
    idle(1);
    rd_chk(1, 32'h0C, 32'h0000_0041, "w8_cnt_41");

    // Reset while counting: aborts at once.
    #20 rstn = 1'b0;
    rd_chk(1, 32'h0C, 32'h0000_0000, "mid_rst_cnt");
    rd_chk(1, 32'h00, 32'h0000_0000, "mid_rst_ctrl");
    @(negedge clk);
    rstn = 1'b1;
    idle(2);
    rd_chk(1, 32'h0C, 32'h0000_0000, "post_rst_cnt");
    rd_chk(1, 32'h10, 32'h0000_0000, "post_rst_stat");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/simple_tmr_slv.md
Name: simple_tmr_slv

Overview:
- Register-mapped timer/compare peripheral.
- It is a slave on the simple bus: addr/we/wd/rd/size, the same signals a router drives per slave.
- Sits behind one router output. The router handles address decode and gates `we`; this block decodes only the low address bits.
- Provides a prescaled up-counter with compare match, one-shot or auto-reload modes, and a level interrupt.

Parameters:
- CNT_W, 32, counter and compare width (1..32); read values are zero-extended to 32 bits.
- PSC_W, 16, prescaler width (1..32).

Ports:
- clk, input, 1, clock.
- rstn, input, 1, reset; asynchronous, active-low.
- addr, input, 32, byte address; only addr[4:0] used.
- we, input, 1, write enable, already qualified by the router select.
- wd, input, 32, write data, lane-aligned (byte n on bits 8n+7:8n).
- rd, output, 32, read data, combinational from addr.
- size, input, 2, access size: 0 byte, 1 halfword, 2/3 word.
- irq, output, 1, level interrupt = STAT.match & CTRL.irq_en.

Behaviour:
- Register map, word index addr[4:2]:
  - 0 CTRL: bit0 en, bit1 auto_reload, bit2 irq_en; other bits read 0.
  - 1 PSC: prescaler divide value.
  - 2 CMP: compare value.
  - 3 CNT: counter; writable.
  - 4 STAT: bit0 match; write-1-to-clear.
  - 5..7: read 0, writes ignored.
- Reads:
  - rd = selected register, zero-extended. Combinational, zero-latency; no side effects.
  - rd is valid whenever addr is stable, regardless of we.
- Write byte enables:
  - size 0: lane addr[1:0].
  - size 1: lanes {addr[1],0} and {addr[1],1}; addr[0] ignored.
  - size 2/3: all four lanes; addr[1:0] ignored.
  - Only enabled lanes update the register. Bits beyond the register width are dropped.
- Write timing: takes effect at the clk edge where we=1; visible on rd the next cycle.
- Reset (rstn low, async): CTRL=0, PSC=0, CMP=all ones, CNT=0, psc_cnt=0, STAT=0, so irq=0 and rd reflects the reset values.
  - Reset mid-count aborts immediately. No tick or match is generated on the release edge.
- Prescaler:
  - While en=1, psc_cnt increments every cycle.
  - When psc_cnt==PSC, psc_cnt<=0 and tick=1 for that cycle. PSC=0 gives a tick every cycle; PSC=N gives a tick every N+1 cycles.
  - While en=0, psc_cnt is held at 0.
  - Any write to PSC clears psc_cnt.
- Counter, on tick:
  - If CNT==CMP: set STAT.match.
    - auto_reload=1: CNT<=0.
    - auto_reload=0 (one-shot): CNT holds and CTRL.en<=0.
  - Else CNT<=CNT+1, wrapping from all ones to 0 without setting match.
- Simultaneous events:
  - Bus write to CNT at the tick edge: the written value wins; no increment and no match that cycle.
  - Bus write to CTRL at the one-shot match edge: the written value wins, including en.
  - W1C of STAT.match at the same edge as a new match: set wins (match=1).
  - Write to CMP at a tick edge: the compare uses the old CMP; the new value applies from the next tick.
- irq is registered-derived only (no combinational path from bus inputs). It stays high until software clears STAT.match or clears irq_en.
- There are no wait states; every access completes in one cycle.

Decomposition:
- Package simple_tmr_pkg holds:
  - register word-index constants (CTRL_IDX..STAT_IDX);
  - CTRL bit positions (EN_B, AR_B, IE_B) and STAT_MATCH_B;
  - size encoding constants (SZ_BYTE, SZ_HALF, SZ_WORD).
- One sub-module, simple_be_gen: combinational addr[1:0] + size -> 4-bit byte enable. It is reusable by other simple-bus slaves.
- Register file, prescaler and counter all stay in simple_tmr_slv.

Test Plan:
- Reset values: assert rstn low mid-cycle, then read all indexes -> rd = 0, 0, 0xFFFFFFFF, 0, 0, 0, 0, 0; irq=0.
- Byte/half write merge:
  - Word write CMP=0x11223344.
  - Byte write wd=0x0000AA00, addr=0x09, size 0 -> CMP reads 0x1122AA44.
  - Half write wd=0xBBCC0000, addr=0x0A, size 1 -> CMP reads 0xBBCCAA44.
- Auto-reload with prescaler:
  - Set PSC=2, CMP=3, CTRL=0x7.
  - Expect a tick every 3 cycles and CNT sequence 0,1,2,3,0.
  - STAT.match and irq rise on the edge where CNT 3->0 (12 cycles after the enable write).
- One-shot:
  - Set PSC=0, CMP=5, CTRL=0x1.
  - After 6 cycles: CNT holds 5, CTRL reads 0x0, STAT=1, irq=0 (irq_en clear).
- W1C vs set collision:
  - Set PSC=0, CMP=0, CTRL=0x7 so a match occurs every cycle.
  - Write STAT=1 -> STAT still reads 1.
  - Disable via CTRL=0x4, then write STAT=1 -> STAT=0, irq=0.
- CNT write priority and wrap:
  - With CNT_W=8, PSC=0, CMP=0x10, en=1: write CNT=0xFE.
  - Next reads 0xFF, then 0x00 with no match.
  - Write CNT=0x40 on a tick edge -> reads 0x40 the next cycle, not 0x41.
